// File: rtl/tagged_msg_tx.sv
// Transmit side of the tagged-message byte link: frames one {tag, payload} message as SOF, header, payload bytes.
// Optional trailing XOR checksum byte is enabled by defining TAGGED_MSG_TX_CSUM_EN.
module tagged_msg_tx #(
  parameter int          DATA_W   = 32,
  parameter int          LEN_W    = 4,
  parameter logic [7:0]  SOF_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_tag,
  input  logic [LEN_W-1:0]  in_len,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  localparam int NBYTES = DATA_W / 8;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(NBYTES);
`ifdef TAGGED_MSG_TX_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

`ifdef TAGGED_MSG_TX_CSUM_EN
  typedef enum logic [2:0] {IDLE, SOF, HDR, PAY, CSUM} stateT;
`else
  typedef enum logic [2:0] {IDLE, SOF, HDR, PAY} stateT;
`endif

  stateT             stateReg, stateNext;
  logic [3:0]        tagReg, tagNext;
  logic [LEN_W-1:0]  lenReg, lenNext;
  logic [LEN_W-1:0]  idxReg, idxNext;
  logic [DATA_W-1:0] dataReg, dataNext;
  logic              outValidReg, outValidNext;
  logic [7:0]        outByteReg, outByteNext;
  logic              outLastReg, outLastNext;
  logic [15:0]       frameCntReg, frameCntNext;
`ifdef TAGGED_MSG_TX_CSUM_EN
  logic [7:0]        csumReg, csumNext;
`endif

  logic              fire;
  logic              moreBytes;
  logic [LEN_W-1:0]  lenEffIn;
  logic [LEN_W-1:0]  idxInc;
  logic [7:0]        hdrByte;

  assign fire      = outValidReg && out_ready;
  assign lenEffIn  = (in_len > MAX_LEN) ? MAX_LEN : in_len;
  assign hdrByte   = {tagReg, lenReg[3:0]};
  // HDR and PAY share the "load next payload byte or wrap up" decision.
  assign moreBytes = (stateReg == HDR) ? (lenReg != '0) : (idxReg != lenReg);
  assign idxInc    = (stateReg == HDR) ? LEN_W'(1) : idxReg + LEN_W'(1);

  assign in_ready  = rst_n && (stateReg == IDLE);
  assign out_valid = outValidReg;
  assign out_byte  = outByteReg;
  assign out_last  = outLastReg;
  assign busy      = (stateReg != IDLE);
  assign frame_cnt = frameCntReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg    <= IDLE;
      tagReg      <= '0;
      lenReg      <= '0;
      idxReg      <= '0;
      dataReg     <= '0;
      outValidReg <= 1'b0;
      outByteReg  <= 8'h00;
      outLastReg  <= 1'b0;
      frameCntReg <= 16'h0000;
`ifdef TAGGED_MSG_TX_CSUM_EN
      csumReg     <= 8'h00;
`endif
    end else begin
      stateReg    <= stateNext;
      tagReg      <= tagNext;
      lenReg      <= lenNext;
      idxReg      <= idxNext;
      dataReg     <= dataNext;
      outValidReg <= outValidNext;
      outByteReg  <= outByteNext;
      outLastReg  <= outLastNext;
      frameCntReg <= frameCntNext;
`ifdef TAGGED_MSG_TX_CSUM_EN
      csumReg     <= csumNext;
`endif
    end
  end

  always_comb begin
    stateNext    = stateReg;
    tagNext      = tagReg;
    lenNext      = lenReg;
    idxNext      = idxReg;
    dataNext     = dataReg;
    outValidNext = outValidReg;
    outByteNext  = outByteReg;
    outLastNext  = outLastReg;
    frameCntNext = frameCntReg;
`ifdef TAGGED_MSG_TX_CSUM_EN
    csumNext     = csumReg;
`endif

    case (stateReg)
      IDLE: begin
        if (in_valid) begin
          tagNext      = in_tag;
          lenNext      = lenEffIn;
          dataNext     = in_data;
          idxNext      = '0;
          outValidNext = 1'b1;
          outByteNext  = SOF_BYTE;
          outLastNext  = 1'b0;
          stateNext    = SOF;
        end
      end
      SOF: begin
        if (fire) begin
          outByteNext = hdrByte;
          outLastNext = !CSUM_ON && (lenReg == '0);
`ifdef TAGGED_MSG_TX_CSUM_EN
          csumNext    = hdrByte;
`endif
          stateNext   = HDR;
        end
      end
      HDR, PAY: begin
        if (fire) begin
          if (moreBytes) begin
            outByteNext = dataReg[7:0];
            dataNext    = dataReg >> 8;
            idxNext     = idxInc;
            outLastNext = !CSUM_ON && (idxInc == lenReg);
`ifdef TAGGED_MSG_TX_CSUM_EN
            csumNext    = csumReg ^ dataReg[7:0];
`endif
            stateNext   = PAY;
          end else begin
`ifdef TAGGED_MSG_TX_CSUM_EN
            outByteNext  = csumReg;
            outLastNext  = 1'b1;
            stateNext    = CSUM;
`else
            outValidNext = 1'b0;
            outByteNext  = 8'h00;
            outLastNext  = 1'b0;
            frameCntNext = frameCntReg + 16'd1;
            stateNext    = IDLE;
`endif
          end
        end
      end
`ifdef TAGGED_MSG_TX_CSUM_EN
      CSUM: begin
        if (fire) begin
          outValidNext = 1'b0;
          outByteNext  = 8'h00;
          outLastNext  = 1'b0;
          frameCntNext = frameCntReg + 16'd1;
          stateNext    = IDLE;
        end
      end
`endif
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tagged_msg_tx.sv
// Bench for tagged_msg_tx: frame-level reference model checked every cycle, plus literal byte sequences.
// Honours TAGGED_MSG_TX_CSUM_EN the same way as the design.
module tb_tagged_msg_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_tag;
  logic [3:0]  in_len;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        busy;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  tagged_msg_tx dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_tag(in_tag), .in_len(in_len), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .out_last(out_last),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [8:0]  expQ[$];      // {last, byte} still owed by the DUT
  logic [7:0]  capQ[$];      // bytes actually handed over
  logic        capLast;
  logic [15:0] modelCnt = 16'h0000;
  int          readyMode = 0;
  int          phase = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Whole frame from the message: SOF, header, clamped payload LSB first, optional XOR.
  task automatic pushFrame(input logic [3:0] tag, input logic [3:0] len, input logic [31:0] data);
    logic [7:0] fb[$];
    logic [7:0] hdr;
    logic [7:0] sum;
    int         lenEff;
    lenEff = (int'(len) > 4) ? 4 : int'(len);
    hdr = {tag, 4'(lenEff)};
    fb.push_back(8'hA5);
    fb.push_back(hdr);
    sum = hdr;
    for (int i = 0; i < lenEff; i++) begin
      fb.push_back(data[8*i +: 8]);
      sum = sum ^ data[8*i +: 8];
    end
`ifdef TAGGED_MSG_TX_CSUM_EN
    fb.push_back(sum);
`endif
    for (int i = 0; i < fb.size(); i++)
      expQ.push_back({(i == fb.size() - 1), fb[i]});
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      expQ.delete();
      modelCnt = 16'h0000;
    end else begin
      chk("in_ready", in_ready, expQ.size() == 0);
      chk("busy", busy, expQ.size() != 0);
      chk("out_valid", out_valid, expQ.size() != 0);
      chk("frame_cnt", frame_cnt, modelCnt);
      if (expQ.size() != 0 && out_valid) begin
        chk("out_byte", out_byte, expQ[0][7:0]);
        chk("out_last", out_last, expQ[0][8]);
        if (out_ready) begin
          capQ.push_back(out_byte);
          capLast = out_last;
          if (expQ[0][8]) modelCnt = modelCnt + 16'd1;
          void'(expQ.pop_front());
        end
      end
      if (in_valid && in_ready) pushFrame(in_tag, in_len, in_data);
    end
  end

  always @(posedge clk) begin
    #1;
    case (readyMode)
      1: begin
        out_ready = (phase == 0);
        phase = (phase + 1) % 3;
      end
      2: out_ready = !(out_valid && out_byte == 8'h33);
      default: out_ready = 1'b1;
    endcase
  end

  task automatic sendMsg(input logic [3:0] tag, input logic [3:0] len, input logic [31:0] data);
    int n = 0;
    in_tag = tag; in_len = len; in_data = data; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("sof_latency", {out_valid, out_byte}, {1'b1, 8'hA5});
  endtask

  task automatic waitIdle();
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((expQ.size() != 0 || !in_ready) && n < 500);
    if (n >= 500) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic checkCap(input string name, input logic [7:0] e[$]);
    chk({name, "_len"}, capQ.size(), e.size());
    for (int i = 0; i < e.size() && i < capQ.size(); i++)
      chk($sformatf("%s_b%0d", name, i), capQ[i], e[i]);
    chk({name, "_last"}, capLast, 1);
    capQ.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1);
  end

  initial begin
    logic [7:0] lit[$];
    rst_n = 1'b0; in_valid = 1'b0; in_tag = '0; in_len = '0; in_data = '0; out_ready = 1'b1;
    #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_byte", out_byte, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_cnt", frame_cnt, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);

    // Single frame, no backpressure
    capQ.delete();
    sendMsg(4'h3, 4'd4, 32'h44332211);
    waitIdle();
`ifdef TAGGED_MSG_TX_CSUM_EN
    lit = '{8'hA5, 8'h34, 8'h11, 8'h22, 8'h33, 8'h44, 8'h70};
`else
    lit = '{8'hA5, 8'h34, 8'h11, 8'h22, 8'h33, 8'h44};
`endif
    checkCap("single", lit);
    chk("single_cnt", frame_cnt, 1);

    // Same frame under 1,0,0 backpressure
    readyMode = 1; phase = 0;
    sendMsg(4'h3, 4'd4, 32'h44332211);
    waitIdle();
    readyMode = 0;
    checkCap("stall", lit);
    chk("stall_cnt", frame_cnt, 2);

    // Zero length
    sendMsg(4'hF, 4'd0, 32'hDEADBEEF);
    waitIdle();
`ifdef TAGGED_MSG_TX_CSUM_EN
    lit = '{8'hA5, 8'hF0, 8'hF0};
`else
    lit = '{8'hA5, 8'hF0};
`endif
    checkCap("zero", lit);

    // Clamped length 9 -> 4
    sendMsg(4'hA, 4'd9, 32'hDDCCBBAA);
    waitIdle();
`ifdef TAGGED_MSG_TX_CSUM_EN
    lit = '{8'hA5, 8'hA4, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hA4};
`else
    lit = '{8'hA5, 8'hA4, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`endif
    checkCap("clamp", lit);
    chk("clamp_cnt", frame_cnt, 4);

    // Reset while stalled on payload byte 2
    readyMode = 2;
    sendMsg(4'h3, 4'd4, 32'h44332211);
    begin
      int n = 0;
      while (!(out_valid && out_byte == 8'h33) && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) chk("stall_timeout", 0, 1);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_frame_cnt", frame_cnt, 0);
    readyMode = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    capQ.delete();
    sendMsg(4'h3, 4'd4, 32'h44332211);
    waitIdle();
`ifdef TAGGED_MSG_TX_CSUM_EN
    lit = '{8'hA5, 8'h34, 8'h11, 8'h22, 8'h33, 8'h44, 8'h70};
`else
    lit = '{8'hA5, 8'h34, 8'h11, 8'h22, 8'h33, 8'h44};
`endif
    checkCap("after_rst", lit);
    chk("after_rst_cnt", frame_cnt, 1);

    // Back-to-back frames
    sendMsg(4'h1, 4'd2, 32'h0000BBAA);
    sendMsg(4'h2, 4'd1, 32'h000000C3);
    sendMsg(4'h7, 4'd3, 32'h00665544);
    waitIdle();
    capQ.delete();
    chk("b2b_cnt", frame_cnt, 4);

    // Counter wrap
    force dut.frameCntReg = 16'hFFFF;
    modelCnt = 16'hFFFF;
    @(posedge clk);
    #2;
    release dut.frameCntReg;
    #1;
    chk("wrap_preload", frame_cnt, 16'hFFFF);
    sendMsg(4'h5, 4'd2, 32'h00002211);
    waitIdle();
    capQ.delete();
    chk("wrap_cnt", frame_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
